// File: rtl/stim_player.sv
// Stimulus player: streams a preloaded vector memory to a downstream DUT over a valid/ready
// handshake with a configurable idle gap, optional looping and a post-run response window.
module stim_player #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned GAP_W     = 4,
  parameter int unsigned DRAIN_CYC = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     start,
  input  logic                     stop,
  input  logic [ADDR_W:0]          len_cfg,
  input  logic [GAP_W-1:0]         gap_cfg,
  input  logic                     loop_cfg,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  input  logic                     resp_valid,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              sent_cnt,
  output logic [31:0]              resp_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [2:0] {StIdle, StFetch, StSend, StGap, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                loop_q, loop_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                fetch_ph_q, fetch_ph_d;
  logic [31:0]         drain_cnt_q, drain_cnt_d;
  logic [31:0]         sent_q, sent_d;
  logic [31:0]         resp_q, resp_d;

  logic [DATA_W-1:0]   mem [Depth];
  logic [DATA_W-1:0]   rd_q;
  logic                last_idx;
  logic [ADDR_W-1:0]   idx_inc;

  // Compared in ADDR_W+1 bits so a full 2^ADDR_W run ends on the top word without overflow.
  assign last_idx = ({1'b0, idx_q} == (len_q - (ADDR_W+1)'(1)));
  assign idx_inc  = idx_q + ADDR_W'(1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    loop_d      = loop_q;
    idx_d       = idx_q;
    fetch_ph_d  = fetch_ph_q;
    drain_cnt_d = drain_cnt_q;
    sent_d      = sent_q;
    resp_d      = resp_q;

    if (resp_valid && (state_q inside {StFetch, StSend, StGap, StDrain})) begin
      resp_d = resp_q + 32'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          len_d      = len_cfg;
          gap_d      = gap_cfg;
          loop_d     = loop_cfg;
          sent_d     = '0;
          resp_d     = '0;
          idx_d      = '0;
          fetch_ph_d = 1'b0;
          state_d    = StFetch;
        end
      end
      // Two cycles: the second re-reads mem[0] so a write landing with start is still seen.
      StFetch: begin
        if (len_q == '0) begin
          state_d = StDone;
        end else if (fetch_ph_q) begin
          fetch_ph_d = 1'b0;
          state_d    = StSend;
        end else begin
          fetch_ph_d = 1'b1;
        end
      end
      StSend: begin
        if (ready_in) begin
          sent_d = sent_q + 32'd1;
          if (last_idx && !loop_q) begin
            drain_cnt_d = '0;
            state_d     = StDrain;
          end else begin
            idx_d = last_idx ? '0 : idx_inc;
            if (gap_q != '0) begin
              gap_cnt_d = gap_q - GAP_W'(1);
              state_d   = StGap;
            end
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StSend;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      StDrain: begin
        if (drain_cnt_q == 32'(DRAIN_CYC - 1)) begin
          state_d = StDone;
        end else begin
          drain_cnt_d = drain_cnt_q + 32'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (stop && (state_q != StIdle)) begin
      state_d    = StIdle;
      fetch_ph_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      loop_q      <= 1'b0;
      idx_q       <= '0;
      fetch_ph_q  <= 1'b0;
      drain_cnt_q <= '0;
      sent_q      <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      loop_q      <= loop_d;
      idx_q       <= idx_d;
      fetch_ph_q  <= fetch_ph_d;
      drain_cnt_q <= drain_cnt_d;
      sent_q      <= sent_d;
      resp_q      <= resp_d;
    end
  end

  // Reading at idx_d keeps rd_q equal to mem[idx_q], so the next word is ready on transfer.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == StIdle)) begin
      mem[wr_addr] <= wr_data;
    end
    rd_q <= mem[idx_d];
  end

  assign valid_out = (state_q == StSend);
  assign data_out  = (state_q == StSend) ? rd_q : '0;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign sent_cnt  = sent_q;
  assign resp_cnt  = resp_q;

endmodule
